// File: rtl/rv32m_divider.sv
// Iterative RV32M divide unit (DIV/DIVU/REM/REMU): radix-2 restoring division,
// one quotient bit per cycle, with the RISC-V divide-by-zero and overflow cases short-circuited.
module rv32m_divider (
   input  logic        aclk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  func,
   input  logic [31:0] din1,
   input  logic [31:0] din2,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] dout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [32:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] div_q, div_d;
   logic        sel_rem_q, sel_rem_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] dout_q, dout_d;

   logic        accept_s;
   logic        signed_op_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic        div_zero_s;
   logic        ovf_s;
   logic        special_s;
   logic [31:0] special_res_s;
   logic [32:0] shift_s;
   logic [32:0] trial_s;
   logic [32:0] iter_rem_s;
   logic [31:0] iter_quo_s;
   logic [31:0] fin_quo_s;
   logic [31:0] fin_rem_s;
   logic [31:0] fin_res_s;
   logic        unused_s;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   // Remainder MSB is always clear between iterations; func[2] is not decoded.
   assign unused_s = ^{func[2], rem_q[32]};

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign dout       = dout_q;

   // Request decode: acceptance, operand magnitudes and special-case detection
   always_comb begin
      accept_s    = req_valid && req_ready_q && (state_q == IDLE);
      signed_op_s = ~func[0];
      if (signed_op_s && din1[31]) begin
         a_mag_s = neg32(din1);
      end else begin
         a_mag_s = din1;
      end
      if (signed_op_s && din2[31]) begin
         b_mag_s = neg32(din2);
      end else begin
         b_mag_s = din2;
      end
      div_zero_s = (din2 == 32'd0);
      ovf_s      = signed_op_s && (din1 == 32'h8000_0000) && (din2 == 32'hFFFF_FFFF);
      special_s  = div_zero_s || ovf_s;
      if (div_zero_s) begin
         special_res_s = func[1] ? din1 : 32'hFFFF_FFFF;
      end else begin
         special_res_s = func[1] ? 32'd0 : 32'h8000_0000;
      end
   end

   // One restoring-division step plus the sign fix-up of its outcome
   always_comb begin
      shift_s = {rem_q[31:0], quo_q[31]};
      trial_s = shift_s - {1'b0, div_q};
      if (trial_s[32]) begin
         iter_rem_s = shift_s;
         iter_quo_s = {quo_q[30:0], 1'b0};
      end else begin
         iter_rem_s = trial_s;
         iter_quo_s = {quo_q[30:0], 1'b1};
      end
      fin_quo_s = neg_quo_q ? neg32(iter_quo_s) : iter_quo_s;
      fin_rem_s = neg_rem_q ? neg32(iter_rem_s[31:0]) : iter_rem_s[31:0];
      fin_res_s = sel_rem_q ? fin_rem_s : fin_quo_s;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = special_s ? DONE : CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (cnt_q == 5'd31) begin
               state_d = DONE;
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: operand capture on acceptance, iterate in CALC
   always_comb begin
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      div_d     = div_q;
      sel_rem_d = sel_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               cnt_d     = 5'd0;
               rem_d     = 33'd0;
               quo_d     = a_mag_s;
               div_d     = b_mag_s;
               sel_rem_d = func[1];
               neg_quo_d = signed_op_s && (din1[31] ^ din2[31]);
               neg_rem_d = signed_op_s && din1[31];
            end else begin
               cnt_d = cnt_q;
            end
         end
         CALC: begin
            cnt_d = cnt_q + 5'd1;
            rem_d = iter_rem_s;
            quo_d = iter_quo_s;
         end
         default: cnt_d = cnt_q;
      endcase
   end

   // Output next values; dout only loads on entry to DONE so it holds through it
   always_comb begin
      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == DONE);
      dout_d       = dout_q;
      if ((state_q == IDLE) && accept_s && special_s) begin
         dout_d = special_res_s;
      end else if ((state_q == CALC) && (cnt_q == 5'd31)) begin
         dout_d = fin_res_s;
      end else begin
         dout_d = dout_q;
      end
   end

   // State register
   always_ff @(posedge aclk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers
   always_ff @(posedge aclk) begin
      if (rst) begin
         cnt_q     <= 5'd0;
         rem_q     <= 33'd0;
         quo_q     <= 32'd0;
         div_q     <= 32'd0;
         sel_rem_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         div_q     <= div_d;
         sel_rem_q <= sel_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   // Output registers
   always_ff @(posedge aclk) begin
      if (rst) begin
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         dout_q       <= 32'd0;
      end else begin
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         dout_q       <= dout_d;
      end
   end

endmodule

// File: tb/tb_rv32m_divider.sv
// Directed self-checking bench for rv32m_divider: results, latency, backpressure
// and mid-operation reset, checked with immediate assertions.
module tb_rv32m_divider;

   logic        aclk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  func;
   logic [31:0] din1;
   logic [31:0] din2;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] dout;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [2:0] F_DIV  = 3'b100;
   localparam logic [2:0] F_DIVU = 3'b101;
   localparam logic [2:0] F_REM  = 3'b110;
   localparam logic [2:0] F_REMU = 3'b111;

   rv32m_divider dut (
      .aclk       (aclk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .func       (func),
      .din1       (din1),
      .din2       (din2),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .dout       (dout)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, measure the cycle resp_valid rises (acceptance edge = cycle 0),
   // optionally hold off resp_ready for 'hold' cycles, then hand the result off.
   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_cyc, input int hold);
      int cyc;
      @(negedge aclk);
      req_valid  = 1'b1;
      func       = f;
      din1       = a;
      din2       = b;
      resp_ready = 1'b0;
      @(posedge aclk);
      #1;
      req_valid = 1'b0;
      func      = 3'b000;
      din1      = 32'h0BAD_F00D;
      din2      = 32'h0000_0000;
      cyc       = 1;
      while (!resp_valid && cyc < 100) begin
         @(posedge aclk);
         #1;
         cyc++;
      end
      chk({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, " dout"}, dout, exp_res);
      chk({tag, " req_ready busy"}, {31'd0, req_ready}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge aclk);
         req_valid = (i == 2);
         func      = F_DIVU;
         din1      = 32'h0000_0001;
         din2      = 32'h0000_0001;
         @(posedge aclk);
         #1;
         chk({tag, " hold resp_valid"}, {31'd0, resp_valid}, 32'd1);
         chk({tag, " hold dout"}, dout, exp_res);
         chk({tag, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
      end
      @(negedge aclk);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge aclk);
      #1;
      chk({tag, " req_ready after handoff"}, {31'd0, req_ready}, 32'd1);
      chk({tag, " resp_valid after handoff"}, {31'd0, resp_valid}, 32'd0);
      @(negedge aclk);
      resp_ready = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      func       = 3'b000;
      din1       = 32'd0;
      din2       = 32'd0;
      repeat (2) @(posedge aclk);
      #1;
      chk("reset req_ready", {31'd0, req_ready}, 32'd1);
      chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("reset dout", dout, 32'd0);
      @(negedge aclk);
      rst = 1'b0;
      resp_ready = 1'b0;

      do_op("divu 100/7",       F_DIVU, 32'd100,        32'd7,          32'd14,         33, 0);
      do_op("remu 100/7",       F_REMU, 32'd100,        32'd7,          32'd2,          33, 0);
      do_op("div -7/2",         F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 0);
      do_op("rem -7/2",         F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 0);
      do_op("rem 7/-2",         F_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33, 0);
      do_op("div 5/0",          F_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0);
      do_op("remu 5/0",         F_REMU, 32'd5,          32'd0,          32'd5,          1,  0);
      do_op("div ovf",          F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0);
      do_op("rem ovf",          F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0);
      do_op("divu no ovf",      F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, 0);
      do_op("div -100/-7",      F_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33, 0);
      do_op("remu max/16",      F_REMU, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F,  33, 0);
      do_op("func2 ignored",    3'b001, 32'd100,        32'd7,          32'd14,         33, 0);
      do_op("backpressure",     F_DIVU, 32'd100,        32'd7,          32'd14,         33, 5);
      do_op("rem -9 by 0",      F_REM,  32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFF7,  1,  0);

      // Reset ten cycles into CALC; the pending result must never appear.
      @(negedge aclk);
      req_valid = 1'b1;
      func      = F_DIVU;
      din1      = 32'd100;
      din2      = 32'd7;
      @(posedge aclk);
      #1;
      req_valid = 1'b0;
      repeat (10) @(posedge aclk);
      @(negedge aclk);
      rst = 1'b1;
      @(posedge aclk);
      #1;
      chk("mid reset resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("mid reset req_ready", {31'd0, req_ready}, 32'd1);
      chk("mid reset dout", dout, 32'd0);
      @(negedge aclk);
      rst = 1'b0;
      resp_ready = 1'b1;
      repeat (40) @(posedge aclk);
      #1;
      chk("aborted no response", {31'd0, resp_valid}, 32'd0);
      chk("aborted idle ready", {31'd0, req_ready}, 32'd1);

      do_op("divu max/1", F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rv32m_divider.md
# rv32m_divider

Iterative RV32M divide unit implementing DIV, DIVU, REM and REMU. It is the multi-cycle responder behind the ALU's divide path: the ALU issues an operand pair and function code, and the unit returns the 32-bit result over a valid/ready handshake. It uses radix-2 restoring division, one quotient bit per cycle, and short-circuits the RISC-V special cases.

## Interface
- No parameters; data width is fixed at 32.
- aclk  in  1  high-speed clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  operands and function valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- func  in  3  RV32M funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU. Only func[1:0] is decoded; func[2] is ignored.
- din1  in  32  dividend (rs1).
- din2  in  32  divisor (rs2).
- resp_valid  out  1  dout holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- dout  out  32  quotient or remainder.

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC on req_valid && req_ready, unless a special case applies.
- IDLE → DONE on acceptance when a special case applies.
- CALC → DONE after exactly 32 iterations.
- DONE → IDLE on resp_valid && resp_ready.
- Request capture: func[1:0], din1 and din2 are registered at acceptance. Inputs are don't-care at all other times.
- Signed ops (func[0]=0):
  - Compute on magnitudes |din1| and |din2|.
  - Negate the quotient when sign(din1) ≠ sign(din2).
  - The remainder takes the sign of din1.
  - Unsigned ops use raw values.
- Datapath:
  - 33-bit partial remainder, 32-bit quotient shift register, 5-bit iteration counter.
  - Each CALC cycle: shift {rem, quo} left by 1; trial-subtract the divisor; if the result is non-negative, keep it and set the quotient LSB to 1, otherwise restore and set it to 0.
- Special cases, resolved at acceptance with no iteration:
  - Divisor zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → din1.
  - Signed overflow (DIV/REM, din1=0x80000000, din2=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- Result selection: func[1]=0 → quotient; func[1]=1 → remainder. Sign fix-up is applied on entry to DONE.
- dout is registered and held stable throughout DONE.

## Timing
- Reset values: req_ready=1, resp_valid=0, dout=0, state=IDLE, counter=0.
- Latency, counting the acceptance edge as cycle 0:
  - Normal ops: resp_valid rises at cycle 33.
  - Special cases: resp_valid rises at cycle 1.
- req_ready is low from the cycle after acceptance until the cycle after response handoff. Back-to-back throughput is therefore one op per 34 cycles minimum.
- Handshake rules:
  - resp_valid never drops without resp_ready.
  - dout must not change while resp_valid=1 && resp_ready=0.
  - resp_ready high before resp_valid has no effect.
- Reset mid-operation (CALC or DONE): the op is aborted with no response. All outputs take their reset values at the next edge, and the pending result is discarded.
- Simultaneous events: rst has priority over every handshake. A req_valid asserted while the unit is in DONE is not accepted until req_ready is high again.

## Test plan
- DIVU 100/7 → dout=14, resp_valid at cycle 33. REMU 100/7 → dout=2.
- DIV 0xFFFFFFF9 (−7) / 2 → dout=0xFFFFFFFD (−3). REM of the same operands → 0xFFFFFFFF (−1). REM 7/0xFFFFFFFE (−2) → 1.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF at cycle 1. REMU 5/0 → 5 at cycle 1.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 1. REM of the same operands → 0.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid. Required: dout stable, req_ready=0, and a req_valid pulse is ignored. After resp_ready=1, req_ready=1 on the next cycle.
- Reset at cycle 10 of CALC. Required: the next cycle has resp_valid=0, req_ready=1, dout=0. A subsequent DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
